enc16b20b_tx_framer: RTL and testbench

- Transmit-side sequencer that drives the 16B/20B encoder's ena/K/Din inputs.
- Takes packetised 16-bit payload from an upstream source over a valid/ready handshake.
- Wraps each packet in start-of-frame and end-of-frame control words, fills gaps with idle commas and inserts periodic alignment commas.
- Sits directly in front of the 16B/20B encoder in the serial TX path.

---
 rtl/enc16b20b_tx_framer_if.sv | 15 +
 rtl/enc16b20b_tx_framer.sv | 150 +++++++++++++++
 tb/tb_enc16b20b_tx_framer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/enc16b20b_tx_framer_if.sv
// Payload stream into the TX framer and the word stream it drives into the 16B/20B encoder.
interface enc16b20b_tx_framer_if;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_last;
  logic        enc_ena;
  logic        enc_k;
  logic [15:0] enc_din;

  modport master (output s_valid, s_data, s_last,
                  input  s_ready, enc_ena, enc_k, enc_din);
  modport slave  (input  s_valid, s_data, s_last,
                  output s_ready, enc_ena, enc_k, enc_din);
endinterface

// File: rtl/enc16b20b_tx_framer.sv
// Frames upstream payload packets with SOF/EOF control words, idle fill and periodic
// alignment idles, and drives the 16B/20B encoder ena/K/Din inputs one word per enabled cycle.
//
// state  | meaning
// OFF    | link disabled, nothing emitted
// IDLE   | between frames, idle commas, waiting for payload and minimum idle gap
// SOF    | emit start-of-frame
// DATA   | pass payload words, idle fill on gaps or alignment
// EOF    | emit end-of-frame, count frame
// DROP   | discard remainder of a truncated packet
module enc16b20b_tx_framer #(
  parameter int MAX_LEN      = 256,
  parameter int IDLE_MIN     = 2,
  parameter int ALIGN_PERIOD = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        link_en,
  enc16b20b_tx_framer_if.slave        bus,
  output logic                        busy,
  output logic                        err_len,
  output logic [15:0]                 frame_cnt
);

  localparam logic [15:0] W_IDLE = 16'hBCBC;
  localparam logic [15:0] W_SOF  = 16'hFBFB;
  localparam logic [15:0] W_EOF  = 16'hFDFD;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(IDLE_MIN + 1);
  localparam int AW = $clog2(ALIGN_PERIOD);

  typedef enum logic [2:0] {S_OFF, S_IDLE, S_SOF, S_DATA, S_EOF, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [LW-1:0] len_cnt_q, len_cnt_d;
  logic [AW-1:0] align_cnt_q, align_cnt_d;
  logic          trunc_q, trunc_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          ena_q;
  logic          k_q, k_d;
  logic [15:0]   din_q, din_d;
  logic          err_q, err_d;
  logic          align_due;
  logic          hs;

  assign align_due   = (align_cnt_q == AW'(ALIGN_PERIOD - 1));
  assign bus.s_ready = link_en && (((state_q == S_DATA) && !align_due) || (state_q == S_DROP));
  assign hs          = bus.s_valid && bus.s_ready;

  assign bus.enc_ena = ena_q;
  assign bus.enc_k   = k_q;
  assign bus.enc_din = din_q;
  assign err_len     = err_q;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = (state_q == S_SOF) || (state_q == S_DATA) ||
                       (state_q == S_DROP) || (state_q == S_EOF);

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    len_cnt_d   = len_cnt_q;
    align_cnt_d = align_cnt_q;
    trunc_d     = trunc_q;
    frame_cnt_d = frame_cnt_q;
    k_d         = k_q;
    din_d       = din_q;
    err_d       = 1'b0;

    if (link_en) begin
      // every enabled cycle emits a word; idle unless a state below overrides it
      k_d   = 1'b1;
      din_d = W_IDLE;
      case (state_q)
        S_OFF: state_d = S_IDLE;
        S_IDLE: begin
          if (idle_cnt_q != IW'(IDLE_MIN)) idle_cnt_d = idle_cnt_q + 1'b1;
          // the idle going out this cycle already counts toward the minimum gap
          if (bus.s_valid && (idle_cnt_q >= IW'(IDLE_MIN - 1))) state_d = S_SOF;
        end
        S_SOF: begin
          if (!align_due) begin
            din_d     = W_SOF;
            len_cnt_d = '0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          if (hs) begin
            k_d       = 1'b0;
            din_d     = bus.s_data;
            len_cnt_d = len_cnt_q + 1'b1;
            if (bus.s_last) begin
              state_d = S_EOF;
            end else if (len_cnt_q == LW'(MAX_LEN - 1)) begin
              err_d   = 1'b1;
              trunc_d = 1'b1;
              state_d = S_EOF;
            end
          end
        end
        S_EOF: begin
          if (!align_due) begin
            din_d       = W_EOF;
            frame_cnt_d = frame_cnt_q + 16'd1;
            idle_cnt_d  = '0;
            trunc_d     = 1'b0;
            state_d     = trunc_q ? S_DROP : S_IDLE;
          end
        end
        S_DROP: begin
          if (hs && bus.s_last) state_d = S_IDLE;
        end
        default: state_d = S_OFF;
      endcase

      if (k_d && (din_d == W_IDLE)) align_cnt_d = '0;
      else                          align_cnt_d = align_cnt_q + 1'b1;
    end else if (state_q == S_IDLE) begin
      state_d = S_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_OFF;
      idle_cnt_q  <= '0;
      len_cnt_q   <= '0;
      align_cnt_q <= '0;
      trunc_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
      ena_q       <= 1'b0;
      k_q         <= 1'b1;
      din_q       <= W_IDLE;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      len_cnt_q   <= len_cnt_d;
      align_cnt_q <= align_cnt_d;
      trunc_q     <= trunc_d;
      frame_cnt_q <= frame_cnt_d;
      ena_q       <= link_en;
      k_q         <= k_d;
      din_q       <= din_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_enc16b20b_tx_framer.sv
// Randomised bench for enc16b20b_tx_framer: packets are framed by a packet-level model and
// the captured encoder word stream is checked for content, idle gaps and alignment spacing.
module tb_enc16b20b_tx_framer;
  localparam int MAX_LEN      = 10;
  localparam int IDLE_MIN     = 2;
  localparam int ALIGN_PERIOD = 8;
  localparam logic [16:0] K_IDLE = {1'b1, 16'hBCBC};
  localparam logic [16:0] K_SOF  = {1'b1, 16'hFBFB};
  localparam logic [16:0] K_EOF  = {1'b1, 16'hFDFD};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        link_en = 1'b0;
  logic        busy;
  logic        err_len;
  logic [15:0] frame_cnt;

  enc16b20b_tx_framer_if bus();

  enc16b20b_tx_framer #(
    .MAX_LEN(MAX_LEN), .IDLE_MIN(IDLE_MIN), .ALIGN_PERIOD(ALIGN_PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .link_en(link_en), .bus(bus),
    .busy(busy), .err_len(err_len), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [16:0] tx_q[$];   // {last, data}
  logic [16:0] exp_q[$];  // {k, din} of every non-idle word expected
  logic [16:0] cap_q[$];  // {k, din} of every emitted word
  int exp_frames = 0;
  int exp_err    = 0;
  int err_seen   = 0;
  int ena_low    = 0;

  logic [16:0] t1_exp[6];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (bus.enc_ena) cap_q.push_back({bus.enc_k, bus.enc_din});
      else             ena_low++;
      if (err_len) err_seen++;
    end
  end

  task automatic add_packet(input int len, input logic [15:0] base, input bit rnd);
    logic [15:0] d;
    exp_q.push_back(K_SOF);
    for (int i = 0; i < len; i++) begin
      d = rnd ? 16'($urandom) : 16'(base * (i + 1));
      tx_q.push_back({(i == len - 1), d});
      if (i < MAX_LEN) exp_q.push_back({1'b0, d});
    end
    exp_q.push_back(K_EOF);
    exp_frames++;
    if (len > MAX_LEN) exp_err++;
  endtask

  // Drives tx_q through the handshake; called and returning at a falling edge.
  task automatic run_phase(input int gap_pct, input int pause_at, input int abort_at);
    int cyc = 0, drain = 0, pos = 0, pause_left = 0;
    bit paused = 0, hs;
    logic [16:0] w;
    cap_q.delete();
    err_seen = 0;
    ena_low  = 0;
    while ((tx_q.size() > 0 || drain < 12) && cyc < 2000 && !(abort_at >= 0 && cyc >= abort_at)) begin
      if (pause_at >= 0 && !paused && cyc >= pause_at && busy) begin
        paused     = 1;
        pause_left = 3;
      end
      link_en = (pause_left == 0);
      if (pause_left > 0) pause_left--;
      if (tx_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        bus.s_valid = 1'b1;
        {bus.s_last, bus.s_data} = tx_q[0];
      end else begin
        bus.s_valid = 1'b0;
        bus.s_last  = 1'($urandom);
        bus.s_data  = 16'($urandom);
      end
      #1;
      if (!link_en) check_eq("ready_paused", bus.s_ready, 0);
      hs = bus.s_valid && bus.s_ready;
      w  = (tx_q.size() > 0) ? tx_q[0] : 17'h0;
      @(posedge clk);
      #1;
      if (hs) begin
        void'(tx_q.pop_front());
        if (pos < MAX_LEN) check_eq("latency", {bus.enc_k, bus.enc_din}, {1'b0, w[15:0]});
        pos = w[16] ? 0 : pos + 1;
      end
      if (tx_q.size() == 0) drain++;
      @(negedge clk);
      cyc++;
    end
    if (abort_at < 0) check_eq("phase_done", tx_q.size(), 0);
  endtask

  task automatic compare_stream(input string tag, input bit strict_align, input bit exact_gap);
    logic [16:0] nonidle[$];
    int run = 0, max_run = 0, gap = 0, min_gap = 1000, odd = 0;
    bit in_frame = 0, seen_eof = 0;
    foreach (cap_q[i]) begin
      if (cap_q[i] == K_IDLE) begin
        if (strict_align && in_frame && run != ALIGN_PERIOD - 1) odd++;
        run = 0;
        gap++;
      end else begin
        nonidle.push_back(cap_q[i]);
        run++;
        if (run > max_run) max_run = run;
        if (cap_q[i] == K_SOF) begin
          in_frame = 1;
          if (seen_eof && gap < min_gap) min_gap = gap;
        end
        if (cap_q[i] == K_EOF) begin
          in_frame = 0;
          seen_eof = 1;
          gap      = 0;
        end
      end
    end
    check_eq({tag, "_count"}, nonidle.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < nonidle.size()) check_eq({tag, "_word"}, nonidle[i], exp_q[i]);
    check_eq({tag, "_align_run"}, (max_run <= ALIGN_PERIOD - 1), 1);
    if (strict_align) check_eq({tag, "_align_pos"}, odd, 0);
    if (exact_gap) check_eq({tag, "_idle_gap"}, min_gap, IDLE_MIN);
    else           check_eq({tag, "_idle_gap"}, (min_gap >= IDLE_MIN), 1);
    check_eq({tag, "_err_len"}, err_seen, exp_err);
    check_eq({tag, "_frame_cnt"}, frame_cnt, 16'(exp_frames));
    exp_q.delete();
    exp_err = 0;
  endtask

  initial begin
    int idx;
    t1_exp = '{K_SOF, {1'b0, 16'h1111}, {1'b0, 16'h2222}, {1'b0, 16'h3333}, K_EOF, K_IDLE};
    bus.s_valid = 1'b0;
    bus.s_data  = 16'h0;
    bus.s_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ena", bus.enc_ena, 0);
    check_eq("rst_k", bus.enc_k, 1);
    check_eq("rst_din", bus.enc_din, 16'hBCBC);
    check_eq("rst_err", err_len, 0);
    check_eq("rst_frames", frame_cnt, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("off_ena", bus.enc_ena, 0);

    // single 3-word packet, exact framing
    add_packet(3, 16'h1111, 0);
    run_phase(0, -1, -1);
    idx = -1;
    foreach (cap_q[i]) if (idx < 0 && cap_q[i] == K_SOF) idx = i;
    check_eq("p1_lead_idles", (idx >= IDLE_MIN), 1);
    for (int i = 0; i < 6; i++)
      check_eq("p1_seq", (idx >= 0 && idx + i < cap_q.size()) ? cap_q[idx + i] : 17'h0, t1_exp[i]);
    compare_stream("p1", 1, 0);

    // back-to-back single-word packets: minimum idle gap exactly
    add_packet(1, 16'hA5A5, 0);
    add_packet(1, 16'h5A5A, 0);
    run_phase(0, -1, -1);
    compare_stream("p2", 1, 1);

    // truncation at MAX_LEN, then a normal packet; and s_last exactly on MAX_LEN
    add_packet(MAX_LEN + 4, 16'h0101, 0);
    add_packet(3, 16'h0707, 0);
    add_packet(MAX_LEN, 16'h0303, 0);
    run_phase(0, -1, -1);
    compare_stream("p3", 1, 0);

    // alignment idles inside long continuous frames
    add_packet(MAX_LEN, 16'h1000, 0);
    add_packet(MAX_LEN, 16'h2000, 0);
    add_packet(9, 16'h3000, 0);
    run_phase(0, -1, -1);
    compare_stream("p4", 1, 0);

    // random lengths, data and valid gaps
    for (int p = 0; p < 8; p++) add_packet($urandom_range(1, MAX_LEN + 3), 16'h0, 1);
    run_phase(25, -1, -1);
    compare_stream("p5", 0, 0);

    // link_en dropped for 3 cycles mid-frame
    for (int p = 0; p < 3; p++) add_packet($urandom_range(5, 9), 16'h0, 1);
    run_phase(20, 6, -1);
    compare_stream("p6", 0, 0);
    check_eq("p6_ena_low", ena_low, 3);

    // reset during DATA
    for (int i = 0; i < 9; i++) tx_q.push_back({(i == 8), 16'(16'h4400 + i)});
    run_phase(0, -1, 8);
    check_eq("p7_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("p7_ena", bus.enc_ena, 0);
    check_eq("p7_k", bus.enc_k, 1);
    check_eq("p7_din", bus.enc_din, 16'hBCBC);
    check_eq("p7_frames", frame_cnt, 0);
    check_eq("p7_busy", busy, 0);
    check_eq("p7_ready", bus.s_ready, 0);
    @(negedge clk);
    link_en     = 1'b0;
    bus.s_valid = 1'b0;
    tx_q.delete();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("p7_ena_after", bus.enc_ena, 0);
    check_eq("p7_frames_after", frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
